// File: rtl/rv_decode_stage_if.sv
// Handshake bundle around the RV32I decode stage.
//   Upstream side  : in_valid, in_ready, instr, in_pc
//   Downstream side: out_valid, out_ready and the decoded fields
//                    (opcode, rd, rs1, rs2, func3, func7, imm, fmt, illegal, out_pc)
// Modports:
//   master - the environment (fetch + register read) driving instructions and out_ready
//   slave  - the decode stage itself
interface rv_decode_stage_if #(
    parameter int unsigned XLEN = 32
);
    localparam int unsigned ILEN  = 32;
    localparam int unsigned REG_W = 5;

    // upstream (fetch -> decode)
    logic              in_valid;
    logic              in_ready;
    logic [ILEN-1:0]   instr;
    logic [XLEN-1:0]   in_pc;

    // downstream (decode -> register read / execute)
    logic              out_valid;
    logic              out_ready;
    logic [6:0]        opcode;
    logic [REG_W-1:0]  rd;
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic [2:0]        func3;
    logic [6:0]        func7;
    logic [XLEN-1:0]   imm;
    logic [2:0]        fmt;
    logic              illegal;
    logic [XLEN-1:0]   out_pc;

    modport master (
        output in_valid, instr, in_pc, out_ready,
        input  in_ready, out_valid, opcode, rd, rs1, rs2, func3, func7,
               imm, fmt, illegal, out_pc
    );

    modport slave (
        input  in_valid, instr, in_pc, out_ready,
        output in_ready, out_valid, opcode, rd, rs1, rs2, func3, func7,
               imm, fmt, illegal, out_pc
    );
endinterface

// File: rtl/rv_decode_stage.sv
// Registered RV32I decode stage sitting between instruction fetch and
// register read / execute. Each accepted instruction is split into its
// fields, its immediate is fully sign-extended, illegal encodings are
// flagged, and the PC travels alongside. A two-entry output/skid buffer
// keeps full throughput and never drops an instruction under backpressure.
// Ports:
//   clk    - clock, all state updates on posedge
//   rst_n  - synchronous reset, active low
//   flush  - discard every buffered instruction (redirect)
//   bus    - rv_decode_stage_if.slave: in_valid/in_ready/instr/in_pc in,
//            out_valid/out_ready plus the decoded bundle out
module rv_decode_stage #(
    parameter int unsigned XLEN     = 32,
    parameter bit          EN_UTYPE = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    rv_decode_stage_if.slave    bus
);
    localparam int unsigned REG_W = 5;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_ILL = 3'd7;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // One decoded instruction as held in the output and skid registers.
    typedef struct packed {
        logic [6:0]       opcode;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [2:0]       func3;
        logic [6:0]       func7;
        logic [XLEN-1:0]  imm;
        logic [2:0]       fmt;
        logic             illegal;
        logic [XLEN-1:0]  pc;
    } dec_t;

    // Widen a 32-bit signed immediate to the datapath width.
    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    logic [31:0] ins;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [2:0]  fmt_c;
    logic        legal_c;
    dec_t        dec;

    assign ins = bus.instr;
    assign f3  = ins[14:12];
    assign f7  = ins[31:25];

    // Classify the opcode and apply the per-opcode legality rules.
    always_comb begin : classify
        fmt_c   = FMT_ILL;
        legal_c = 1'b0;
        case (ins[6:0])
            OPC_OP: begin
                fmt_c   = FMT_R;
                // only the base and alternate func7; alternate only for add/sub and srl/sra
                legal_c = (f7 == F7_BASE) ||
                          ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101)));
            end
            OPC_OPIMM: begin
                fmt_c   = FMT_I;
                legal_c = 1'b1;
            end
            OPC_LOAD: begin
                fmt_c   = FMT_I;
                legal_c = !((f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111));
            end
            OPC_JALR: begin
                fmt_c   = FMT_I;
                legal_c = (f3 == 3'b000);
            end
            OPC_STORE: begin
                fmt_c   = FMT_S;
                legal_c = (f3 <= 3'b010);
            end
            OPC_BRANCH: begin
                fmt_c   = FMT_B;
                legal_c = (f3[2:1] != 2'b01);
            end
            OPC_LUI, OPC_AUIPC: begin
                fmt_c   = FMT_U;
                legal_c = EN_UTYPE;
            end
            OPC_JAL: begin
                fmt_c   = FMT_J;
                legal_c = 1'b1;
            end
            default: begin
                fmt_c   = FMT_ILL;
                legal_c = 1'b0;
            end
        endcase
    end

    // Build the decoded bundle; every field not used by the format stays 0.
    always_comb begin : decode
        dec        = '0;
        dec.opcode = ins[6:0];
        dec.pc     = bus.in_pc;
        if (legal_c) begin
            dec.fmt = fmt_c;
            case (fmt_c)
                FMT_R: begin
                    dec.rd    = ins[11:7];
                    dec.rs1   = ins[19:15];
                    dec.rs2   = ins[24:20];
                    dec.func3 = f3;
                    dec.func7 = f7;
                end
                FMT_I: begin
                    dec.rd    = ins[11:7];
                    dec.rs1   = ins[19:15];
                    dec.func3 = f3;
                    dec.imm   = sext32({{20{ins[31]}}, ins[31:20]});
                end
                FMT_S: begin
                    dec.rs1   = ins[19:15];
                    dec.rs2   = ins[24:20];
                    dec.func3 = f3;
                    dec.imm   = sext32({{20{ins[31]}}, ins[31:25], ins[11:7]});
                end
                FMT_B: begin
                    dec.rs1   = ins[19:15];
                    dec.rs2   = ins[24:20];
                    dec.func3 = f3;
                    dec.imm   = sext32({{19{ins[31]}}, ins[31], ins[7],
                                        ins[30:25], ins[11:8], 1'b0});
                end
                FMT_U: begin
                    dec.rd    = ins[11:7];
                    dec.imm   = sext32({ins[31:12], 12'b0});
                end
                FMT_J: begin
                    dec.rd    = ins[11:7];
                    dec.imm   = sext32({{11{ins[31]}}, ins[31], ins[19:12],
                                        ins[20], ins[30:21], 1'b0});
                end
                default: begin
                    dec.fmt = FMT_ILL;
                end
            endcase
        end else begin
            dec.fmt     = FMT_ILL;
            dec.illegal = 1'b1;
        end
    end

    // Output register plus skid register; in_ready is kept as its own flop.
    dec_t out_q,  out_d;
    dec_t skid_q, skid_d;
    logic out_valid_q,  out_valid_d;
    logic skid_valid_q, skid_valid_d;
    logic in_ready_q,   in_ready_d;
    logic in_fire_c;
    logic out_fire_c;

    assign in_fire_c  = bus.in_valid & in_ready_q;
    assign out_fire_c = out_valid_q & bus.out_ready;

    always_ff @(posedge clk) begin : state_reg
        if (!rst_n) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            out_q        <= out_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end

    // Buffer control: flush wins, then skid drain, then load/forward.
    always_comb begin : next_state
        out_d        = out_q;
        skid_d       = skid_q;
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (skid_valid_q) begin
            // input is blocked while the skid is full; only draining happens
            if (out_fire_c) begin
                out_d        = skid_q;
                skid_valid_d = 1'b0;
            end
        end else if (!out_valid_q || out_fire_c) begin
            out_valid_d = in_fire_c;
            if (in_fire_c) begin
                out_d = dec;
            end
        end else if (in_fire_c) begin
            skid_d       = dec;
            skid_valid_d = 1'b1;
        end
        in_ready_d = !skid_valid_d;
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.opcode    = out_q.opcode;
    assign bus.rd        = out_q.rd;
    assign bus.rs1       = out_q.rs1;
    assign bus.rs2       = out_q.rs2;
    assign bus.func3     = out_q.func3;
    assign bus.func7     = out_q.func7;
    assign bus.imm       = out_q.imm;
    assign bus.fmt       = out_q.fmt;
    assign bus.illegal   = out_q.illegal;
    assign bus.out_pc    = out_q.pc;
endmodule
